// File: rtl/ws2812_rx_decoder.sv
// rtl/ws2812_rx_decoder.sv - GRB single-wire LED receive decoder with chained-LED forwarding
// Classifies high-pulse widths into bits, assembles 24-bit pixels, detects the latch gap.
module ws2812_rx_decoder #(
    parameter int T_MIN    = 15,
    parameter int T_THRESH = 63,
    parameter int T_MAX    = 120,
    parameter int T_RESET  = 5000,
    parameter int PIX_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic             dout,
    output logic [23:0]      grb,
    output logic             pixel_valid,
    output logic [PIX_W-1:0] pixel_index,
    output logic             frame_done,
    output logic [PIX_W-1:0] frame_pixels,
    output logic             bit_error,
    output logic             fwd
);
    localparam int TW = $clog2(T_RESET + 1);
    localparam logic [TW-1:0] MIN_W   = TW'(T_MIN);
    localparam logic [TW-1:0] THR_W   = TW'(T_THRESH);
    localparam logic [TW-1:0] MAX_W   = TW'(T_MAX);
    localparam logic [TW-1:0] RESET_W = TW'(T_RESET);

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             din_m;
    logic             din_s;
    logic             din_d;
    logic             rise;
    logic             fall;
    logic [TW-1:0]    timer;
    logic [23:0]      shreg;
    logic [4:0]       bit_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic             pix_done;
    logic             do_shift;
    logic             do_err;
    logic             do_latch;
    logic             arm_exit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
            din_d <= 1'b0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            din_d <= din_s;
        end
    end

    assign rise     = din_s & ~din_d;
    assign fall     = ~din_s & din_d;
    assign pix_done = (bit_cnt == 5'd24);

    // One timer measures both high widths and low gaps; while arming, any high restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (rise || fall || (state == ARM && din_s)) begin
            timer <= '0;
        end else if (timer != RESET_W) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_shift   = 1'b0;
        do_err     = 1'b0;
        do_latch   = 1'b0;
        arm_exit   = 1'b0;
        case (state)
            ARM: begin
                if (!din_s && timer == RESET_W) begin
                    state_next = IDLE;
                    arm_exit   = 1'b1;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (timer > MAX_W) begin
                    do_err     = 1'b1;
                    state_next = ARM;
                end else if (fall) begin
                    if (timer < MIN_W) begin
                        do_err     = 1'b1;
                        state_next = ARM;
                    end else begin
                        do_shift   = 1'b1;
                        state_next = LOW;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_next = HIGH;
                end else if (timer == RESET_W) begin
                    do_latch   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = ARM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout         <= 1'b0;
            grb          <= '0;
            pixel_valid  <= 1'b0;
            pixel_index  <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            bit_error    <= 1'b0;
            fwd          <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;
            dout        <= fwd & din_s;

            if (do_shift) begin
                shreg   <= {shreg[22:0], (timer >= THR_W)};
                bit_cnt <= bit_cnt + 5'd1;
            end

            if (pix_done) begin
                grb         <= shreg;
                pixel_valid <= 1'b1;
                pixel_index <= pix_cnt;
                bit_cnt     <= '0;
                if (pix_cnt != '1) begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
                // Pixel 0 is consumed locally; everything after it is passed down the chain.
                if (pix_cnt == '0) begin
                    fwd <= 1'b1;
                end
            end

            // pix_cnt is deliberately held here; the discarded frame clears it on ARM exit.
            if (do_err) begin
                bit_error <= 1'b1;
                bit_cnt   <= '0;
                fwd       <= 1'b0;
            end

            if (do_latch) begin
                frame_done   <= 1'b1;
                frame_pixels <= pix_cnt;
                bit_error    <= (bit_cnt != 5'd0);
                pix_cnt      <= '0;
                bit_cnt      <= '0;
                fwd          <= 1'b0;
            end

            if (arm_exit) begin
                pix_cnt <= '0;
                bit_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// tb/tb_ws2812_rx_decoder.sv - randomized self-checking bench for ws2812_rx_decoder
// Frames are described as high/low pulse lists; a pulse-level model predicts the events.
module tb_ws2812_rx_decoder;
    localparam int T_RESET = 1000;
    localparam int GAP     = 1200;
    localparam int PIX_W   = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             din = 1'b0;
    logic             dout;
    logic [23:0]      grb;
    logic             pixel_valid;
    logic [PIX_W-1:0] pixel_index;
    logic             frame_done;
    logic [PIX_W-1:0] frame_pixels;
    logic             bit_error;
    logic             fwd;

    ws2812_rx_decoder #(.T_RESET(T_RESET), .PIX_W(PIX_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .dout         (dout),
        .grb          (grb),
        .pixel_valid  (pixel_valid),
        .pixel_index  (pixel_index),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .bit_error    (bit_error),
        .fwd          (fwd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Event log, written only by the monitor.
    logic [23:0] pv_grb_q[$];
    int          pv_idx_q[$];
    int          pv_cyc_q[$];
    int          fd_pix_q[$];
    int          fd_err_q[$];
    int          err_cyc_q[$];
    int          dout_cnt = 0;
    int          dout_bad = 0;
    logic        d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;

    always @(negedge clk) begin
        if (pixel_valid) begin
            pv_grb_q.push_back(grb);
            pv_idx_q.push_back(int'(pixel_index));
            pv_cyc_q.push_back(cyc);
        end
        if (frame_done) begin
            fd_pix_q.push_back(int'(frame_pixels));
            fd_err_q.push_back(int'(bit_error));
        end
        if (bit_error) err_cyc_q.push_back(cyc);
        // Forwarded data must be din from three clocks earlier.
        if (dout) begin
            dout_cnt++;
            if (!d3) dout_bad++;
        end
        d3 = d2;
        d2 = d1;
        d1 = din;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    int hi_q[$];
    int lo_q[$];
    int fall24_cyc = 0;
    int rise0_cyc = 0;
    int b_pv, b_fd, b_err, b_dout, b_bad;

    logic [23:0] exp_grb[$];
    int exp_fd, exp_fp, exp_fd_err, exp_err, exp_dout;

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_bit(input int hi, input int lo);
        hi_q.push_back(hi);
        lo_q.push_back(lo);
    endtask

    task automatic add_rand_bit(input logic b);
        add_bit(b ? int'($urandom_range(121, 64)) : int'($urandom_range(63, 16)),
                int'($urandom_range(30, 5)));
    endtask

    task automatic add_pixel(input logic [23:0] v);
        for (int k = 23; k >= 0; k--) add_rand_bit(v[k]);
    endtask

    // The rise cycle itself clears the timer, so it reads one less than the high clocks.
    function automatic int width(input int hi);
        return hi - 1;
    endfunction

    task automatic predict(input bit armed);
        int bad;
        int nv;
        logic [23:0] px;
        exp_grb.delete();
        exp_fd = 0; exp_fp = 0; exp_fd_err = 0; exp_err = 0; exp_dout = 0;
        if (armed) begin
            bad = -1;
            for (int i = 0; i < hi_q.size(); i++)
                if (bad < 0 && (width(hi_q[i]) < 15 || width(hi_q[i]) > 120)) bad = i;
            nv = (bad < 0) ? hi_q.size() : bad;
            for (int p = 0; p < nv / 24; p++) begin
                px = '0;
                for (int k = 0; k < 24; k++) px = {px[22:0], (width(hi_q[24*p+k]) >= 63)};
                exp_grb.push_back(px);
            end
            if (bad >= 0) begin
                exp_err  = 1;
                exp_dout = (bad < 24) ? 0 : -1;
            end else begin
                exp_fd     = (nv > 0) ? 1 : 0;
                exp_fp     = nv / 24;
                exp_fd_err = (nv % 24 != 0) ? 1 : 0;
                exp_err    = exp_fd_err;
                for (int i = 24; i < nv; i++) exp_dout += hi_q[i];
            end
        end
    endtask

    task automatic send_frame();
        for (int i = 0; i < hi_q.size(); i++) begin
            if (i == 0) rise0_cyc = cyc;
            hold(1'b1, hi_q[i]);
            if (i == 23) fall24_cyc = cyc;
            hold(1'b0, lo_q[i]);
        end
        hold(1'b0, GAP);
    endtask

    task automatic run_frame(input bit armed);
        predict(armed);
        b_pv = pv_grb_q.size(); b_fd = fd_pix_q.size(); b_err = err_cyc_q.size();
        b_dout = dout_cnt; b_bad = dout_bad;
        send_frame();
        check("pixel_count", 32'(pv_grb_q.size() - b_pv), 32'(exp_grb.size()));
        for (int i = 0; i < exp_grb.size() && b_pv + i < pv_grb_q.size(); i++) begin
            check("grb", 32'(pv_grb_q[b_pv+i]), 32'(exp_grb[i]));
            check("pixel_index", 32'(pv_idx_q[b_pv+i]), 32'(i));
        end
        check("frame_done", 32'(fd_pix_q.size() - b_fd), 32'(exp_fd));
        if (exp_fd != 0 && fd_pix_q.size() > b_fd) begin
            check("frame_pixels", 32'(fd_pix_q[b_fd]), 32'(exp_fp));
            check("latch_error", 32'(fd_err_q[b_fd]), 32'(exp_fd_err));
        end
        check("bit_error", 32'(err_cyc_q.size() - b_err), 32'(exp_err));
        if (exp_dout >= 0) check("dout_high", 32'(dout_cnt - b_dout), 32'(exp_dout));
        check("dout_delay", 32'(dout_bad - b_bad), 32'd0);
        check("fwd_after", 32'(fwd), 32'd0);
        hi_q.delete();
        lo_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grb"}, 32'(grb), 32'd0);
        check({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        check({tag, "_pixel_index"}, 32'(pixel_index), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_frame_pixels"}, 32'(frame_pixels), 32'd0);
        check({tag, "_bit_error"}, 32'(bit_error), 32'd0);
        check({tag, "_fwd"}, 32'(fwd), 32'd0);
        check({tag, "_dout"}, 32'(dout), 32'd0);
    endtask

    initial begin
        logic [23:0] v;
        int lat;
        int np;
        int nx;
        int j;

        reset = 1'b1;
        din   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        hold(1'b0, GAP);

        // Single red pixel with fixed 80/45 and 40/85 bit shapes.
        v = 24'hFF0000;
        for (int k = 23; k >= 0; k--) add_bit(v[k] ? 80 : 40, v[k] ? 45 : 85);
        run_frame(1'b1);
        lat = (pv_cyc_q.size() > b_pv) ? pv_cyc_q[b_pv] - fall24_cyc : -1;
        check("pixel_latency", 32'(lat), 32'd4);

        add_pixel(24'h123456);
        add_pixel(24'hABCDEF);
        add_pixel(24'h000001);
        run_frame(1'b1);

        // Glitch mid-pixel, then a clean pixel after re-arming.
        add_pixel(24'($urandom()));
        hi_q[10] = 10;
        run_frame(1'b1);
        add_pixel(24'($urandom()));
        run_frame(1'b1);

        // Stuck-high line: error once the timer passes T_MAX.
        add_bit(200, 20);
        run_frame(1'b1);
        lat = (err_cyc_q.size() > b_err) ? err_cyc_q[b_err] - rise0_cyc : -1;
        // 2 sync stages, rise clears the timer on the 3rd edge, 121 more to read 121, 1 to register.
        check("error_latency", 32'(lat), 32'd125);

        for (int k = 0; k < 12; k++) add_rand_bit(1'($urandom_range(1, 0)));
        run_frame(1'b1);

        // Width boundaries: 62->0, 63->1, 15 accepted, 120 accepted; 14 and 121 rejected.
        add_bit(63, 20);
        add_bit(64, 20);
        add_bit(16, 20);
        add_bit(121, 20);
        for (int k = 0; k < 20; k++) add_rand_bit(1'($urandom_range(1, 0)));
        run_frame(1'b1);
        add_pixel(24'($urandom()));
        hi_q[5] = 15;
        run_frame(1'b1);
        add_pixel(24'($urandom()));
        hi_q[3] = 122;
        run_frame(1'b1);

        for (int f = 0; f < 5; f++) begin
            np = int'($urandom_range(2, 0));
            nx = int'($urandom_range(12, 0));
            if (np == 0 && nx == 0) nx = 1;
            for (int p = 0; p < np; p++) add_pixel(24'($urandom()));
            for (int k = 0; k < nx; k++) add_rand_bit(1'($urandom_range(1, 0)));
            if ($urandom_range(3, 0) == 0) begin
                j = int'($urandom_range(hi_q.size() - 1, 0));
                hi_q[j] = ($urandom_range(1, 0) == 1) ? int'($urandom_range(15, 2))
                                                      : int'($urandom_range(180, 122));
            end
            run_frame(1'b1);
        end

        // Reset while forwarding pixel 1.
        add_pixel(24'hC0FFEE);
        add_pixel(24'($urandom()));
        for (int i = 0; i < 30; i++) begin
            hold(1'b1, hi_q[i]);
            hold(1'b0, lo_q[i]);
        end
        hi_q.delete();
        lo_q.delete();
        check("pre_reset_fwd", 32'(fwd), 32'd1);
        check("pre_reset_grb", 32'(grb), 32'hC0FFEE);
        din = 1'b1;
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold(1'b1, 10);
        hold(1'b0, 30);
        // Not yet armed: this pixel must be ignored.
        add_pixel(24'($urandom()));
        run_frame(1'b0);
        add_pixel(24'($urandom()));
        run_frame(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
